alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU with single-cycle ops and iterative shifts / shift-add multiply
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             taken,
    output logic             illegal
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] func_q, func_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic zero_q, zero_d, taken_q, taken_d, illegal_q, illegal_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] cls;
    logic [3:0] f;
    logic [LW-1:0] shamt;
    logic [WIDTH-1:0] res1, step_a, step_acc, fin;
    logic eq, lts, ltu, flag, tk, ill, multi, mul;
    always_comb begin
        cls = alu_ctrl[5:4];
        f = alu_ctrl[3:0];
        shamt = op_b[LW-1:0];
        eq = op_a == op_b;
        lts = $signed(op_a) < $signed(op_b);
        ltu = op_a < op_b;
        res1 = '0;
        flag = 1'b0;
        tk = 1'b0;
        ill = 1'b0;
        case (cls)
            2'b01: case (f)
                4'd0: res1 = op_a + op_b;
                4'd1: res1 = op_a - op_b;
                4'd2: res1 = op_a & op_b;
                4'd3: res1 = op_a | op_b;
                4'd4: res1 = op_a ^ op_b;
                4'd5: res1 = ~op_a;
                4'd6, 4'd7, 4'd8: res1 = op_a;
                4'd9: res1 = '0;
                default: ill = 1'b1;
            endcase
            2'b00: begin
                case (f)
                    4'd0: flag = eq;
                    4'd1: flag = !eq;
                    4'd2: flag = lts;
                    4'd3: flag = ltu;
                    4'd4: flag = !lts;
                    4'd5: flag = !ltu;
                    default: ill = 1'b1;
                endcase
                res1 = {{(WIDTH-1){1'b0}}, flag};
            end
            2'b11: begin
                res1 = op_a - op_b;
                case (f)
                    4'd0: tk = eq;
                    4'd1: tk = !eq;
                    4'd2: tk = lts;
                    4'd3: tk = !lts;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) res1 = '0;
        // a zero shift amount completes like any single-cycle op
        multi = cls == 2'b01 && (f == 4'd9 || (f >= 4'd6 && f <= 4'd8 && shamt != '0));
    end
    always_comb begin
        mul = func_q == 4'd9;
        step_acc = acc_q + (b_q[0] ? a_q : '0);
        step_a = func_q == 4'd7 ? a_q >> 1 :
                 func_q == 4'd8 ? {a_q[WIDTH-1], a_q[WIDTH-1:1]} : a_q << 1;
        fin = mul ? step_acc : step_a;
    end
    always_comb begin
        state_d = state_q;
        func_d = func_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        result_d = result_q;
        zero_d = zero_q;
        taken_d = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = multi ? EXEC : DONE;
                func_d = f;
                a_d = op_a;
                b_d = op_b;
                acc_d = '0;
                cnt_d = multi ? (f == 4'd9 ? CW'(WIDTH) : CW'(shamt)) : '0;
                result_d = res1;
                zero_d = res1 == '0;
                taken_d = tk;
                illegal_d = ill;
            end
            EXEC: begin
                a_d = step_a;
                b_d = b_q >> 1;
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    result_d = fin;
                    zero_d = fin == '0;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            func_q <= '0;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            result_q <= '0;
            zero_q <= 1'b0;
            taken_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q <= func_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            result_q <= result_d;
            zero_q <= zero_d;
            taken_q <= taken_d;
            illegal_q <= illegal_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result = result_q;
    assign zero = zero_q;
    assign taken = taken_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (WIDTH 16)
module tb_alu_exec_unit;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [5:0] alu_ctrl = '0;
    logic [15:0] op_a = '0, op_b = '0;
    logic in_ready, out_valid, zero, taken, illegal;
    logic [15:0] result;
    int n_chk = 0, n_fail = 0;
    typedef struct {
        logic [15:0] res;
        logic z;
        logic t;
        logic il;
        int lat;
    } exp_t;
    exp_t sbq[$];
    always #5 clk = ~clk;
    alu_exec_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .taken(taken), .illegal(illegal)
    );
    function automatic exp_t model(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [3:0] f;
        int sh;
        logic fl;
        f = c[3:0];
        sh = int'(b[3:0]);
        e.res = '0; e.t = 1'b0; e.il = 1'b0; e.lat = 1; fl = 1'b0;
        case (c[5:4])
            2'b01: case (f)
                4'd0: e.res = a + b;
                4'd1: e.res = a - b;
                4'd2: e.res = a & b;
                4'd3: e.res = a | b;
                4'd4: e.res = a ^ b;
                4'd5: e.res = ~a;
                4'd6: begin e.res = a << sh; e.lat = sh + 1; end
                4'd7: begin e.res = a >> sh; e.lat = sh + 1; end
                4'd8: begin e.res = $signed(a) >>> sh; e.lat = sh + 1; end
                4'd9: begin e.res = a * b; e.lat = 17; end
                default: e.il = 1'b1;
            endcase
            2'b00: begin
                case (f)
                    4'd0: fl = a == b;
                    4'd1: fl = a != b;
                    4'd2: fl = $signed(a) < $signed(b);
                    4'd3: fl = a < b;
                    4'd4: fl = $signed(a) >= $signed(b);
                    4'd5: fl = a >= b;
                    default: e.il = 1'b1;
                endcase
                e.res = {15'b0, fl};
            end
            2'b11: begin
                e.res = a - b;
                case (f)
                    4'd0: e.t = a == b;
                    4'd1: e.t = a != b;
                    4'd2: e.t = $signed(a) < $signed(b);
                    4'd3: e.t = $signed(a) >= $signed(b);
                    default: e.il = 1'b1;
                endcase
            end
            default: e.il = 1'b1;
        endcase
        if (e.il) begin e.res = '0; e.t = 1'b0; end
        e.z = e.res == '0;
        return e;
    endfunction
    task automatic send(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        sbq.push_back(model(c, a, b));
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctrl = 6'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    endtask
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    endtask
    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_chk++; if ({result, zero, taken, illegal} !== 19'd0) begin
            n_fail++; $display("FAIL reset outputs: got %h/%b%b%b want 0000/000", result, zero, taken, illegal);
        end
    endtask
    task automatic test_add;
        exp_t e;
        int n;
        send(6'b010000, 16'h7FFF, 16'h0001);
        wait_out(n);
        e = sbq.pop_front();
        n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL add latency: got %0d want %0d", n, e.lat); end
        n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
            n_fail++; $display("FAIL add result: got %h/%b%b%b want %h/%b%b%b", result, zero, taken, illegal, e.res, e.z, e.t, e.il);
        end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add in_ready in DONE: got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL add return idle: got ready %b valid %b want 1 0", in_ready, out_valid);
        end
    endtask
    task automatic test_sub_cmp;
        logic [5:0] c[8] = '{6'b010001, 6'b000010, 6'b000011, 6'b000000, 6'b000001, 6'b000100, 6'b000101, 6'b010101};
        logic [15:0] a[8] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h00AA, 16'h00AA, 16'h8000, 16'h0002, 16'h0F0F};
        logic [15:0] b[8] = '{16'h1234, 16'h0001, 16'h0001, 16'h00AA, 16'h00AA, 16'h7FFF, 16'hFFFF, 16'h1111};
        exp_t e;
        int n;
        for (int i = 0; i < 8; i++) begin
            send(c[i], a[i], b[i]);
            wait_out(n);
            e = sbq.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL cmp%0d latency: got %0d want %0d", i, n, e.lat); end
            n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
                n_fail++; $display("FAIL cmp%0d result: got %h/%b%b%b want %h/%b%b%b", i, result, zero, taken, illegal, e.res, e.z, e.t, e.il);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_shift;
        logic [5:0] c[5] = '{6'b011000, 6'b011000, 6'b010110, 6'b010111, 6'b011000};
        logic [15:0] a[5] = '{16'h8000, 16'h8000, 16'h0001, 16'hF0F0, 16'h4000};
        logic [15:0] b[5] = '{16'h0004, 16'h0010, 16'h000F, 16'hFFF3, 16'h0001};
        exp_t e;
        int n;
        for (int i = 0; i < 5; i++) begin
            send(c[i], a[i], b[i]);
            wait_out(n);
            e = sbq.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL shift%0d latency: got %0d want %0d", i, n, e.lat); end
            n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
                n_fail++; $display("FAIL shift%0d result: got %h/%b%b%b want %h/%b%b%b", i, result, zero, taken, illegal, e.res, e.z, e.t, e.il);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_mul;
        logic [15:0] a[3] = '{16'h0100, 16'hFFFF, 16'h0000};
        logic [15:0] b[3] = '{16'h0101, 16'hFFFF, 16'h1234};
        exp_t e;
        int n, busy;
        for (int i = 0; i < 3; i++) begin
            send(6'b011001, a[i], b[i]);
            n = 1; busy = 0;
            while (!out_valid && n < 40) begin
                if (in_ready) busy++;
                @(posedge clk); #1; n++;
            end
            e = sbq.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL mul%0d latency: got %0d want %0d", i, n, e.lat); end
            n_chk++; if (busy !== 0) begin n_fail++; $display("FAIL mul%0d in_ready during EXEC: got %0d cycles want 0", i, busy); end
            n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
                n_fail++; $display("FAIL mul%0d result: got %h/%b%b%b want %h/%b%b%b", i, result, zero, taken, illegal, e.res, e.z, e.t, e.il);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_branch_stall_illegal;
        logic [5:0] c[7] = '{6'b101111, 6'b110000, 6'b110001, 6'b110011, 6'b110100, 6'b011010, 6'b000110};
        logic [15:0] a[7] = '{16'h1111, 16'h0005, 16'h0005, 16'hFFFE, 16'h0001, 16'h0001, 16'h0001};
        logic [15:0] b[7] = '{16'h2222, 16'h0005, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0001};
        exp_t e;
        int n;
        out_ready = 1'b0;
        send(6'b110010, 16'hFFFE, 16'h0003);
        wait_out(n);
        e = sbq.pop_front();
        n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL blt latency: got %0d want %0d", n, e.lat); end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; alu_ctrl = 6'b010000; op_a = 16'h0001; op_b = 16'h0001;
            @(posedge clk); #1;
            n_chk++; if ({out_valid, in_ready, result, zero, taken, illegal} !== {2'b10, e.res, e.z, e.t, e.il}) begin
                n_fail++; $display("FAIL blt stall%0d: got v%b r%b %h/%b%b%b want v1 r0 %h/%b%b%b",
                    k, out_valid, in_ready, result, zero, taken, illegal, e.res, e.z, e.t, e.il);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL blt release: got ready %b valid %b want 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 7; i++) begin
            send(c[i], a[i], b[i]);
            wait_out(n);
            e = sbq.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL br%0d latency: got %0d want %0d", i, n, e.lat); end
            n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
                n_fail++; $display("FAIL br%0d result: got %h/%b%b%b want %h/%b%b%b", i, result, zero, taken, illegal, e.res, e.z, e.t, e.il);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_reset_mid_mul;
        exp_t e;
        int n;
        send(6'b011001, 16'h1234, 16'h5678);
        void'(sbq.pop_back());
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; alu_ctrl = 6'b010000;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        n_chk++; if ({in_ready, out_valid, result, zero, taken, illegal} !== {2'b10, 19'd0}) begin
            n_fail++; $display("FAIL mid-mul reset: got r%b v%b %h/%b%b%b want r1 v0 0000/000", in_ready, out_valid, result, zero, taken, illegal);
        end
        send(6'b010000, 16'h0FF0, 16'h0011);
        wait_out(n);
        e = sbq.pop_front();
        n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL post-reset add latency: got %0d want %0d", n, e.lat); end
        n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
            n_fail++; $display("FAIL post-reset add result: got %h/%b%b%b want %h/%b%b%b", result, zero, taken, illegal, e.res, e.z, e.t, e.il);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_back_to_back;
        exp_t e;
        int n;
        for (int i = 0; i < 30; i++) begin
            send({2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))}, 16'($urandom), 16'($urandom));
            wait_out(n);
            e = sbq.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL rnd%0d latency: got %0d want %0d", i, n, e.lat); end
            n_chk++; if ({result, zero, taken, illegal} !== {e.res, e.z, e.t, e.il}) begin
                n_fail++; $display("FAIL rnd%0d result: got %h/%b%b%b want %h/%b%b%b", i, result, zero, taken, illegal, e.res, e.z, e.t, e.il);
            end
            @(posedge clk); #1;
        end
    endtask
    initial begin
        test_reset;
        test_add;
        test_sub_cmp;
        test_shift;
        test_mul;
        test_branch_stall_illegal;
        test_reset_mid_mul;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
